// File: rtl/shared_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : shared_bus_responder
// Description : Target side of the per-core shared bus. Round-robin
//               arbitration among NUM_CORES initiators. A granted request is
//               serviced from an internal global memory (addr[15]=0) or
//               forwarded to an external device-register port (addr[15]=1).
//               Completion is a one-cycle per-core ready strobe. Read data is
//               broadcast on core_read_val, which is valid the cycle after
//               the ready strobe.
// Ports       : clk, reset (sync, active-high)
//               core_addr/core_wren/core_rden/core_write_val : per-core requests
//               core_ready (per-core strobe), core_read_val (broadcast data)
//               dev_addr/dev_wren/dev_rden/dev_write_val     : device request
//               dev_read_val/dev_ready                       : device response
// Revision    : 1.0 - initial release
// ============================================================================
module shared_bus_responder #(
  parameter int NUM_CORES          = 4,
  parameter int GLOBAL_MEMORY_SIZE = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES*16-1:0]   core_addr,
  input  logic [NUM_CORES-1:0]      core_wren,
  input  logic [NUM_CORES-1:0]      core_rden,
  input  logic [NUM_CORES*16-1:0]   core_write_val,
  output logic [NUM_CORES-1:0]      core_ready,
  output logic [15:0]               core_read_val,
  output logic [15:0]               dev_addr,
  output logic                      dev_wren,
  output logic                      dev_rden,
  output logic [15:0]               dev_write_val,
  input  logic [15:0]               dev_read_val,
  input  logic                      dev_ready
);

  localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW = $clog2(GLOBAL_MEMORY_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DEV  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [GW-1:0]   gnt, gnt_next;
  logic [GW-1:0]   rr_ptr, rr_ptr_next;
  logic [GW-1:0]   gnt_inc;

  logic [15:0]     addr_arr  [NUM_CORES];
  logic [15:0]     wdata_arr [NUM_CORES];
  logic [NUM_CORES-1:0] req;

  generate
    for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
      assign addr_arr[k]  = core_addr[k*16 +: 16];
      assign wdata_arr[k] = core_write_val[k*16 +: 16];
    end
  endgenerate

  assign req = core_wren | core_rden;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  logic [GW-1:0] winner;
  logic          winner_found;
  logic [GW-1:0] cand;

  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = GW'((int'(rr_ptr) + i) % NUM_CORES);
      if (!winner_found && req[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  // Values of the currently granted core
  logic [15:0] gnt_addr;
  logic [15:0] gnt_wdata;
  logic        gnt_wren;
  logic        gnt_rden;

  assign gnt_addr  = addr_arr[gnt];
  assign gnt_wdata = wdata_arr[gnt];
  assign gnt_wren  = core_wren[gnt];
  assign gnt_rden  = core_rden[gnt];

  assign gnt_inc = (gnt == GW'(NUM_CORES - 1)) ? '0 : gnt + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state;
    gnt_next    = gnt;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (winner_found) begin
          gnt_next   = winner;
          state_next = addr_arr[winner][15] ? DEV : MEM;
        end
      end
      MEM: begin
        rr_ptr_next = gnt_inc;
        state_next  = IDLE;
      end
      DEV: begin
        if (dev_ready) begin
          rr_ptr_next = gnt_inc;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion strobe and device port, decoded from state/gnt/dev_ready
  always_comb begin
    core_ready    = '0;
    dev_addr      = 16'h0000;
    dev_wren      = 1'b0;
    dev_rden      = 1'b0;
    dev_write_val = 16'h0000;
    if (state == MEM) begin
      core_ready[gnt] = 1'b1;
    end
    if (state == DEV) begin
      dev_addr      = gnt_addr;
      dev_write_val = gnt_wdata;
      dev_wren      = gnt_wren;
      // Both strobes set means write
      dev_rden      = gnt_rden & ~gnt_wren;
      if (dev_ready) begin
        core_ready[gnt] = 1'b1;
      end
    end
  end

  // Global memory: upper address bits below bit 15 alias onto the same words.
  logic [15:0]   mem [GLOBAL_MEMORY_SIZE];
  logic [AW-1:0] mem_idx;
  logic          mem_we;

  assign mem_idx = gnt_addr[AW-1:0];
  assign mem_we  = (state == MEM) && gnt_wren && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= gnt_wdata;
    end
  end

  // Read data register: loaded at the end of the ready cycle so it is valid
  // the following cycle; holds across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_read_val <= 16'h0000;
    end else if ((state == MEM) && !gnt_wren) begin
      core_read_val <= mem[mem_idx];
    end else if ((state == DEV) && dev_ready && !gnt_wren) begin
      core_read_val <= dev_read_val;
    end
  end

endmodule
`default_nettype wire

// File: doc/shared_bus_responder.md
Name: shared_bus_responder

Overview:
- Target end of the per-core shared bus: the `shared_addr` / `shared_wren` / `shared_rden` / `shared_ready` / `shared_write_val` / `shared_read_val` signals driven by each core.
- Arbitrates round-robin among `NUM_CORES` initiators.
- Services the granted request from an internal global memory or forwards it to an external device-register port.
- Returns completion via a per-core ready strobe and a broadcast read-data bus.
- Sits at top level between the core array and the devices.

Parameters:
- `NUM_CORES`, 4, number of initiator cores (1..16).
- `GLOBAL_MEMORY_SIZE`, 4096, words of global memory (power of two, ≤16384).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `core_addr`  in  `NUM_CORES`*16  per-core address; core k in bits [16k+15:16k]
- `core_wren`  in  `NUM_CORES`  per-core write request
- `core_rden`  in  `NUM_CORES`  per-core read request
- `core_write_val`  in  `NUM_CORES`*16  per-core write data
- `core_ready`  out  `NUM_CORES`  per-core completion strobe
- `core_read_val`  out  16  read data, broadcast to all cores
- `dev_addr`  out  16  device register address
- `dev_wren`  out  1  device write strobe
- `dev_rden`  out  1  device read strobe
- `dev_write_val`  out  16  device write data
- `dev_read_val`  in  16  device read data, valid when `dev_ready`
- `dev_ready`  in  1  device completion

Behaviour:
- Request from core k: `core_wren[k]` | `core_rden[k]`.
  - Initiator holds addr/data/strobes stable until it sees `core_ready[k]`=1.
  - If both strobes are set, treat as a write.
- Address decode on granted `addr[15]`:
  - 0 → global memory, word index `addr[log2(GLOBAL_MEMORY_SIZE)-1:0]`; upper bits ignored (aliasing).
  - 1 → device port.
- Global memory: internal synchronous single-port RAM, 1-cycle read. Contents are not cleared by reset.
- FSM states: IDLE, MEM, DEV.
  - IDLE:
    - If any request, pick winner = first requester at or after `rr_ptr` (wrapping). Register winner index in `gnt`.
    - Go to MEM if `addr[15]`=0, else DEV.
    - No request → stay.
  - MEM (exactly 1 cycle):
    - Present `addr[gnt]`; write enable = `wren[gnt]`.
    - Assert `core_ready[gnt]`=1.
    - `rr_ptr` ← `(gnt+1) mod NUM_CORES`.
    - → IDLE.
  - DEV:
    - `dev_addr`/`dev_write_val` = granted core's values.
    - `dev_wren`/`dev_rden` = granted strobes, held until `dev_ready`.
    - In the cycle `dev_ready`=1:
      - assert `core_ready[gnt]`=1;
      - capture `dev_read_val` if read;
      - `rr_ptr` ← `gnt+1` wrapped;
      - → IDLE.
    - No timeout.
- `core_ready` is one-hot or zero, only ever asserted in the completion cycle, and combinationally decoded from state/`gnt`/`dev_ready`.
- Read data timing:
  - `core_read_val` becomes valid the cycle after the ready cycle (this matches the core's registered data select).
  - Updated only after a read completion: memory q for MEM reads, registered `dev_read_val` for DEV reads.
  - Holds its value otherwise, including across writes.
- Throughput:
  - Memory access: 2 cycles per transaction (IDLE + MEM).
  - Device access: 1 + device latency.
  - A core re-requesting the cycle after its ready is a new request and is arbitrated normally.
- Requests arriving while busy wait; non-granted cores see `core_ready`=0 and stay stalled.
- `dev_*` outputs are 0 outside DEV.
- Reset (sync), including mid-DEV:
  - state=IDLE, `gnt`=0, `rr_ptr`=0;
  - `core_ready`=0, `core_read_val`=0;
  - `dev_wren`/`dev_rden`=0, `dev_addr`=0, `dev_write_val`=0;
  - a pending device transaction is abandoned.
- Wrap-around: `rr_ptr` after granting core `NUM_CORES`-1 is 0.
- `NUM_CORES`=1: arbitration is degenerate; timing is unchanged.

Test Plan:
- Single core 0 writes 0x4010←0xBEEF (request cycle 0): `core_ready[0]` at cycle 1 only. It then reads 0x4010: `core_ready[0]` at cycle 3, `core_read_val`=0xBEEF at cycle 4 and held while idle.
- Aliasing: write 0x4005←0x1234, read 0x7005 (`GLOBAL_MEMORY_SIZE`=4096 → same word) → 0x1234.
- Contention: all 4 cores request reads at the same cycle after reset → grants in order 0,1,2,3, with ready pulses at cycles 1,3,5,7. Core 2 then re-requests alone → granted immediately. Core 3 and core 0 then request together with `rr_ptr`=3 → core 3 first.
- Device read 0x8002 with `dev_ready` after 3 cycles, `dev_read_val`=0x00A5:
  - `dev_rden` held 3 cycles, 0 afterwards;
  - `core_ready` in the `dev_ready` cycle;
  - `core_read_val`=0x00A5 the next cycle.
- Device write in progress, `reset` pulsed for 1 cycle before `dev_ready`:
  - next cycle all `dev_*`=0, `core_ready`=0, `core_read_val`=0, state IDLE;
  - subsequent memory read still returns previously written data.
- Core issuing both wren and rden to 0x4020 with data 0x5555 → treated as write; a later read returns 0x5555 and `core_read_val` is unchanged by the write itself.
